// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default link constants
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - per-bit cycle counter, bit_end on the last cycle of each serial bit
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign bit_end = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer (start, LSB-first data, optional parity, stop)
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_e            state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [IW-1:0]        bit_idx, bit_idx_nxt;
  logic                 bit_end, accept;
  logic                 serial_nxt, busy_nxt, done_nxt;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign accept = (state == IDLE) && tx_start;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (tx_start) state_nxt = START;
      START:  if (bit_end)  state_nxt = DATA;
      DATA: begin
        if (bit_end && (bit_idx == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: if (bit_end)  state_nxt = STOP;
      STOP:   if (bit_end)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the pad flop changes together with the FSM.
  always_comb begin
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    if (accept) begin
      shreg_nxt   = tx_data;
      bit_idx_nxt = '0;
    end else if ((state == DATA) && bit_end) begin
      shreg_nxt   = shreg >> 1;
      bit_idx_nxt = bit_idx + 1'b1;
    end
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == STOP) && bit_end;
    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_nxt = parity_bit;
`endif
      default: serial_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      bit_idx    <= '0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      shreg      <= shreg_nxt;
      bit_idx    <= bit_idx_nxt;
      serial_out <= serial_nxt;
      tx_busy    <= busy_nxt;
      tx_done    <= done_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         parity_bit <= 1'b0;
    else if (accept) parity_bit <= (^tx_data) ^ PARITY_ODD;
  end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer (table, corner sequences, random)
module tb_uart_tx_serializer;

  localparam int CPB  = 4;
  localparam int DB   = 8;
  localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 2 + DB + P;
  localparam int FL = NB * CPB;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_start;
  logic [DB-1:0] tx_data;
  logic          tx_busy, tx_done, serial_out;

  int errors = 0;
  int checks = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(PODD)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;     // bit i = i-th bit on the line, no parity
    logic       par_even;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line level per cycle for a frame, followed by one idle-high cycle.
  function automatic logic [63:0] expand(input logic [15:0] bits);
    logic [63:0] v = '0;
    for (int c = 0; c < FL; c++) v[c] = bits[c / CPB];
    v[FL] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] model_bits(input logic [7:0] d);
    logic [15:0] b = '1;
    int ones = 0;
    b[0] = 1'b0;
    for (int i = 0; i < DB; i++) begin
      b[i+1] = d[i];
      ones += int'(d[i]);
    end
    if (P == 1) b[DB+1] = ((ones % 2) == 1) ^ PODD;
    return b;
  endfunction

  function automatic logic [15:0] table_bits(input vec_t v);
    logic [15:0] b = '1;
`ifdef UART_TX_PARITY_EN
    b[8:0] = v.frame[8:0];
    b[9]   = v.par_even ^ PODD;
`else
    b[9:0] = v.frame;
`endif
    return b;
  endfunction

  task automatic run_frame(input logic [7:0] d, input bit prestarted, input bit noise,
                           input bit b2b, input logic [7:0] nd,
                           output logic [63:0] line, output logic [63:0] busyv, output int dones);
    line  = '0;
    busyv = '0;
    dones = 0;
    if (!prestarted) begin
      tx_start = 1'b1;
      tx_data  = d;
    end
    @(posedge clk); #1;
    tx_start = 1'b0;
    for (int c = 0; c <= FL; c++) begin
      line[c]  = serial_out;
      busyv[c] = tx_busy;
      if (tx_done) dones++;
      if (c == FL) begin
        if (b2b) begin
          tx_start = 1'b1;
          tx_data  = nd;
        end
      end else begin
        if (noise) begin
          tx_start = ((c % 7) == 3) && (c < FL - 1);
          tx_data  = tx_start ? 8'h3C : 8'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    if (!b2b) begin
      tx_start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  logic [63:0] l1, l2, b1, b2;
  int          d1, d2, cnt;
  logic [7:0]  cur, nxt;
  bit          pre, b2b, noise;
  logic [63:0] busy_exp;

  initial begin
    busy_exp = (64'd1 << FL) - 64'd1;
    vecs[0] = '{8'hA5, 10'h34A, 1'b0};
    vecs[1] = '{8'h00, 10'h200, 1'b0};
    vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[3] = '{8'h81, 10'h302, 1'b0};
    vecs[4] = '{8'h55, 10'h2AA, 1'b0};
    vecs[5] = '{8'h07, 10'h20E, 1'b1};
    vecs[6] = '{8'h03, 10'h206, 1'b0};
    vecs[7] = '{8'h3C, 10'h278, 1'b0};

    rst = 1'b1; tx_start = 1'b0; tx_data = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_hold", {61'd0, serial_out, tx_busy, tx_done}, 64'b100);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_reset", {61'd0, serial_out, tx_busy, tx_done}, 64'b100);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].data, 1'b0, 1'b0, 1'b0, 8'h00, l1, b1, d1);
      check($sformatf("table_line_%02h", vecs[i].data), l1, expand(table_bits(vecs[i])));
      check($sformatf("table_busy_%02h", vecs[i].data), b1, busy_exp);
      check($sformatf("table_done_%02h", vecs[i].data), 64'(d1), 64'd1);
`ifdef UART_TX_PARITY_EN
      check($sformatf("parity_bit_%02h", vecs[i].data), 64'(l1[(DB+1)*CPB]), 64'(vecs[i].par_even ^ PODD));
`endif
    end

    run_frame(8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, l1, b1, d1);
    run_frame(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, l2, b2, d2);
    check("b2b_line0", l1, expand(table_bits(vecs[1])));
    check("b2b_line1", l2, expand(table_bits(vecs[2])));
    check("b2b_busy_total", 64'($countones(b1) + $countones(b2)), 64'(2 * FL));
    check("b2b_gap", {62'd0, b1[FL], b2[0]}, 64'b01);
    check("b2b_dones", 64'(d1 + d2), 64'd2);

    run_frame(8'h81, 1'b0, 1'b1, 1'b0, 8'h00, l1, b1, d1);
    check("ignored_line", l1, expand(table_bits(vecs[3])));
    check("ignored_done", 64'(d1), 64'd1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      cnt += int'(tx_busy) + int'(tx_done);
      @(posedge clk); #1;
    end
    check("ignored_not_queued", 64'(cnt), 64'd0);

    tx_start = 1'b1; tx_data = 8'h55;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    check("midframe_bit3", {62'd0, serial_out, tx_busy}, 64'b01);
    #2 rst = 1'b1;
    #1 check("midframe_abort", {61'd0, serial_out, tx_busy, tx_done}, 64'b100);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      cnt += int'(tx_busy) + int'(tx_done);
      @(posedge clk); #1;
    end
    check("midframe_no_done", 64'(cnt), 64'd0);
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'h00, l1, b1, d1);
    check("post_reset_line", l1, expand(table_bits(vecs[4])));
    check("post_reset_busy", b1, busy_exp);

    cur = 8'($urandom);
    pre = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nxt   = 8'($urandom);
      b2b   = (i < 15) && ($urandom_range(1, 0) == 1);
      noise = ($urandom_range(1, 0) == 1);
      run_frame(cur, pre, noise, b2b, nxt, l1, b1, d1);
      check($sformatf("rand%0d_line_%02h", i, cur), l1, expand(model_bits(cur)));
      check($sformatf("rand%0d_busy", i), b1, busy_exp);
      check($sformatf("rand%0d_done", i), 64'(d1), 64'd1);
      pre = b2b;
      cur = nxt;
      if (!b2b) repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
